cbu_updn_mod_counter: RTL and testbench

//  Parametrised cascadable up/down modulo counter: next generation of the CBU

---
 rtl/cbu_updn_mod_counter_if.sv | 29 ++
 rtl/cbu_updn_mod_counter.sv | 65 ++++++
 tb/tb_cbu_updn_mod_counter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cbu_updn_mod_counter_if.sv
// Bus bundle for the CBU up/down modulo counter: control inputs, load data,
// chaining carry and the count/flag outputs. Clock and clear are kept as
// plain ports on the counter itself.
interface cbu_updn_mod_counter_if #(
   parameter int WIDTH = 8
);
   logic             SD;
   logic             LOAD;
   logic [WIDTH-1:0] D;
   logic             EN;
   logic             CAI;
   logic             UP;
   logic             OVF_CLR;
   logic [WIDTH-1:0] Q;
   logic             CAO;
   logic             OVF;

   // Controller side: drives the counter controls, observes count and flags.
   modport master (
      output SD, LOAD, D, EN, CAI, UP, OVF_CLR,
      input  Q, CAO, OVF
   );

   // Counter side.
   modport slave (
      input  SD, LOAD, D, EN, CAI, UP, OVF_CLR,
      output Q, CAO, OVF
   );
endinterface

// File: rtl/cbu_updn_mod_counter.sv
// Cascadable up/down modulo counter. Counts 0..MODULUS-1 in either direction,
// wraps or saturates at the terminal value, supports preset, clamped load and
// a sticky overflow flag. CAO is combinational so chained stages step on the
// same edge as the stage below them.
module cbu_updn_mod_counter #(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MODULUS  = 256,
   parameter bit              SATURATE = 1'b0
) (
   input  logic                  CLK,
   input  logic                  CD,
   cbu_updn_mod_counter_if.slave bus
);

   // Largest legal count; also the terminal value when counting up.
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] load_val;
   logic             stepping;
   logic             at_term;

   // Terminal value, step qualification and clamped load data.
   always_comb begin
      term     = bus.UP ? MAX_Q : '0;
      stepping = bus.EN && bus.CAI;
      at_term  = (bus.Q == term);
      load_val = (64'(bus.D) < MODULUS) ? bus.D : MAX_Q;
   end

   // Carry out: this stage is about to roll over (or attempt to) on the next edge.
   assign bus.CAO = stepping && at_term && !CD && !bus.SD && !bus.LOAD;

   // Count register and sticky overflow flag; CD > SD > LOAD > step > hold.
   // NOTE: the clear is sampled on the clock edge only, so it lives inside the
   // posedge-only sensitivity list rather than being an asynchronous branch.
   always_ff @(posedge CLK) begin
      if (CD) begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, which chained stages and the OVF logic rely on.
         bus.Q   <= '0;
         bus.OVF <= 1'b0;
      end else begin
         if (bus.SD) begin
            bus.Q <= MAX_Q;
         end else if (bus.LOAD) begin
            bus.Q <= load_val;
         end else if (stepping) begin
            if (!at_term) begin
               bus.Q <= bus.UP ? bus.Q + WIDTH'(1) : bus.Q - WIDTH'(1);
            end else if (!SATURATE) begin
               bus.Q <= bus.UP ? '0 : MAX_Q;
            end
         end

         // A step taken at the terminal value sets the flag; set beats clear.
         if (!bus.SD && !bus.LOAD && stepping && at_term) begin
            bus.OVF <= 1'b1;
         end else if (bus.OVF_CLR) begin
            bus.OVF <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cbu_updn_mod_counter.sv
// Self-checking bench for cbu_updn_mod_counter: directed vector table,
// multi-cycle corner sequences, a two-stage cascade and randomized stimulus
// compared against an arithmetic reference model.
module tb_cbu_updn_mod_counter;

   logic CLK;
   logic cd8, cd10, cds, cdc;

   int total = 0;
   int bad   = 0;

   cbu_updn_mod_counter_if #(.WIDTH(8)) bus8 ();
   cbu_updn_mod_counter_if #(.WIDTH(4)) bus10 ();
   cbu_updn_mod_counter_if #(.WIDTH(4)) buss ();
   cbu_updn_mod_counter_if #(.WIDTH(4)) buslo ();
   cbu_updn_mod_counter_if #(.WIDTH(4)) bushi ();

   cbu_updn_mod_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0))
      u_c8  (.CLK(CLK), .CD(cd8),  .bus(bus8));
   cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(10),  .SATURATE(1'b0))
      u_c10 (.CLK(CLK), .CD(cd10), .bus(bus10));
   cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(10),  .SATURATE(1'b1))
      u_cs  (.CLK(CLK), .CD(cds),  .bus(buss));
   cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(16),  .SATURATE(1'b0))
      u_lo  (.CLK(CLK), .CD(cdc),  .bus(buslo));
   cbu_updn_mod_counter #(.WIDTH(4), .MODULUS(16),  .SATURATE(1'b0))
      u_hi  (.CLK(CLK), .CD(cdc),  .bus(bushi));

   // High stage steps only when the low stage carries out.
   assign bushi.CAI = buslo.CAO;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      bit       cd, sd, load;
      bit [3:0] d;
      bit       en, cai, up, ovf_clr;
      bit       exp_cao;
      int       exp_q;
      bit       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outputs are sampled 2 time units after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Reference model: one clock edge of a modulo-m counter from the rules.
   function automatic void model_step(input int m, input bit sat,
         input bit cd, input bit sd, input bit load, input int d,
         input bit en, input bit cai, input bit up, input bit clr,
         inout int q, inout bit ovf, output bit cao);
      int term;
      bit go, hit;
      term = up ? m - 1 : 0;
      go   = en && cai;
      cao  = go && (q == term) && !cd && !sd && !load;
      hit  = go && (q == term) && !sd && !load;
      if (cd) begin
         q   = 0;
         ovf = 1'b0;
      end else begin
         if (sd)
            q = m - 1;
         else if (load)
            q = (d < m) ? d : m - 1;
         else if (go && !(sat && q == term))
            q = (q + (up ? 1 : m - 1)) % m;
         if (hit)
            ovf = 1'b1;
         else if (clr)
            ovf = 1'b0;
      end
   endfunction

   task automatic vec(input bit cd, input bit sd, input bit load, input bit [3:0] d,
         input bit en, input bit cai, input bit up, input bit clr,
         input bit cao, input int q, input bit ovf);
      vec_t v;
      v.cd = cd; v.sd = sd; v.load = load; v.d = d; v.en = en; v.cai = cai;
      v.up = up; v.ovf_clr = clr; v.exp_cao = cao; v.exp_q = q; v.exp_ovf = ovf;
      vecs.push_back(v);
   endtask

   initial begin
      int  mq10, mqs;
      bit  movf10, movfs, mcao10, mcaos;
      bit  r_cd, r_sd, r_ld, r_en, r_cai, r_up, r_clr;
      int  r_d;

      // Directed vectors for the MODULUS=10 wrap counter.
      //   cd sd ld  d  en cai up clr | cao  q  ovf
      vec(1, 0, 0, 0,  0, 0, 0, 0,   0,  0, 0);
      vec(1, 1, 1, 5,  1, 1, 1, 0,   0,  0, 0);   // CD beats everything
      vec(0, 1, 1, 3,  0, 0, 0, 0,   0,  9, 0);   // SD beats LOAD
      vec(0, 0, 1, 15, 0, 0, 0, 0,   0,  9, 0);   // clamp
      vec(0, 0, 1, 3,  0, 0, 0, 0,   0,  3, 0);
      vec(0, 0, 0, 0,  1, 1, 1, 0,   0,  4, 0);
      vec(0, 0, 0, 0,  1, 1, 0, 0,   0,  3, 0);   // direction change same edge
      vec(0, 0, 1, 0,  0, 0, 0, 0,   0,  0, 0);
      vec(0, 0, 0, 0,  1, 1, 0, 1,   1,  9, 1);   // set beats OVF_CLR
      vec(0, 0, 0, 0,  0, 1, 1, 0,   0,  9, 1);   // EN=0 at terminal
      vec(0, 0, 0, 0,  1, 0, 1, 0,   0,  9, 1);   // CAI=0 at terminal
      vec(0, 0, 0, 0,  0, 0, 0, 1,   0,  9, 0);
      vec(0, 0, 0, 0,  1, 1, 1, 0,   1,  0, 1);
      vec(0, 0, 0, 0,  0, 0, 0, 1,   0,  0, 0);
      vec(0, 1, 0, 0,  1, 1, 0, 0,   0,  9, 0);   // SD never sets OVF
      vec(0, 0, 1, 2,  1, 1, 1, 0,   0,  2, 0);   // LOAD never sets OVF
      vec(1, 0, 0, 0,  1, 1, 1, 0,   0,  0, 0);

      // Quiet defaults everywhere.
      {cd8, cd10, cds, cdc} = 4'b1111;
      {bus8.SD, bus8.LOAD, bus8.EN, bus8.CAI, bus8.UP, bus8.OVF_CLR} = '0;
      {bus10.SD, bus10.LOAD, bus10.EN, bus10.CAI, bus10.UP, bus10.OVF_CLR} = '0;
      {buss.SD, buss.LOAD, buss.EN, buss.CAI, buss.UP, buss.OVF_CLR} = '0;
      {buslo.SD, buslo.LOAD, buslo.EN, buslo.CAI, buslo.UP, buslo.OVF_CLR} = '0;
      {bushi.SD, bushi.LOAD, bushi.EN, bushi.UP, bushi.OVF_CLR} = '0;
      bus8.D = '0; bus10.D = '0; buss.D = '0; buslo.D = '0; bushi.D = '0;
      #1;
      check("cao_in_reset_8", bus8.CAO, 0);
      tick();
      check("reset_q8", bus8.Q, 0);
      check("reset_ovf8", bus8.OVF, 0);
      check("reset_q10", bus10.Q, 0);
      check("reset_qs", buss.Q, 0);

      // Vector table on the MODULUS=10 wrap counter.
      foreach (vecs[i]) begin
         cd10 = vecs[i].cd; bus10.SD = vecs[i].sd; bus10.LOAD = vecs[i].load;
         bus10.D = vecs[i].d; bus10.EN = vecs[i].en; bus10.CAI = vecs[i].cai;
         bus10.UP = vecs[i].up; bus10.OVF_CLR = vecs[i].ovf_clr;
         #1;
         check($sformatf("vec%0d_cao", i), bus10.CAO, vecs[i].exp_cao);
         tick();
         check($sformatf("vec%0d_q", i), bus10.Q, vecs[i].exp_q);
         check($sformatf("vec%0d_ovf", i), bus10.OVF, vecs[i].exp_ovf);
      end

      // Full 256-count up sweep on the 8-bit counter.
      cd8 = 1'b0; bus8.EN = 1'b1; bus8.CAI = 1'b1; bus8.UP = 1'b1;
      for (int i = 0; i < 256; i++) begin
         #1;
         check($sformatf("sweep%0d_cao", i), bus8.CAO, (i == 255) ? 1 : 0);
         tick();
         check($sformatf("sweep%0d_q", i), bus8.Q, (i + 1) % 256);
         check($sformatf("sweep%0d_ovf", i), bus8.OVF, (i == 255) ? 1 : 0);
      end
      bus8.EN = 1'b0;

      // Down count from 0 on MODULUS=10: 9,8,...,0,9, then clear without wrap.
      cd10 = 1'b1; {bus10.SD, bus10.LOAD, bus10.OVF_CLR} = '0;
      tick();
      cd10 = 1'b0; bus10.EN = 1'b1; bus10.CAI = 1'b1; bus10.UP = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
         check($sformatf("down%0d_q", i), bus10.Q, (i == 10) ? 9 : 9 - i);
         check($sformatf("down%0d_ovf", i), bus10.OVF, 1);
      end
      bus10.OVF_CLR = 1'b1;
      tick();
      check("down_clr_q", bus10.Q, 8);
      check("down_clr_ovf", bus10.OVF, 0);
      bus10.OVF_CLR = 1'b0; bus10.EN = 1'b0;

      // Saturating counter from 7 upward: 8,9,9,9.
      cds = 1'b0; buss.LOAD = 1'b1; buss.D = 4'd7;
      tick();
      check("sat_load_q", buss.Q, 7);
      buss.LOAD = 1'b0; buss.EN = 1'b1; buss.CAI = 1'b1; buss.UP = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("sat%0d_cao", i), buss.CAO, (i >= 2) ? 1 : 0);
         tick();
         check($sformatf("sat%0d_q", i), buss.Q, (i == 0) ? 8 : 9);
         check($sformatf("sat%0d_ovf", i), buss.OVF, (i >= 2) ? 1 : 0);
      end
      buss.EN = 1'b0;

      // Two-stage cascade: 0x0F -> 0x10, then 0xFF -> 0x00.
      cdc = 1'b0;
      buslo.LOAD = 1'b1; buslo.D = 4'hF; bushi.LOAD = 1'b1; bushi.D = 4'h0;
      tick();
      buslo.LOAD = 1'b0; bushi.LOAD = 1'b0;
      buslo.EN = 1'b1; buslo.CAI = 1'b1; buslo.UP = 1'b1;
      bushi.EN = 1'b1; bushi.UP = 1'b1;
      tick();
      check("casc1_val", {bushi.Q, buslo.Q}, 8'h10);
      check("casc1_hi_ovf", bushi.OVF, 0);
      buslo.EN = 1'b0;
      buslo.LOAD = 1'b1; buslo.D = 4'hF; bushi.LOAD = 1'b1; bushi.D = 4'hF;
      tick();
      buslo.LOAD = 1'b0; bushi.LOAD = 1'b0; buslo.EN = 1'b1;
      #1;
      check("casc2_hi_cao", bushi.CAO, 1);
      tick();
      check("casc2_val", {bushi.Q, buslo.Q}, 8'h00);
      check("casc2_hi_ovf", bushi.OVF, 1);
      buslo.EN = 1'b0;

      // Randomized stimulus on both MODULUS=10 counters against the model.
      cd10 = 1'b1; cds = 1'b1;
      tick();
      mq10 = 0; mqs = 0; movf10 = 1'b0; movfs = 1'b0;
      for (int i = 0; i < 400; i++) begin
         r_cd  = ($urandom_range(0, 29) == 0);
         r_sd  = ($urandom_range(0, 19) == 0);
         r_ld  = ($urandom_range(0, 9) == 0);
         r_d   = $urandom_range(0, 15);
         r_en  = ($urandom_range(0, 3) != 0);
         r_cai = ($urandom_range(0, 4) != 0);
         r_up  = $urandom_range(0, 1);
         r_clr = ($urandom_range(0, 7) == 0);
         cd10 = r_cd; bus10.SD = r_sd; bus10.LOAD = r_ld; bus10.D = 4'(r_d);
         bus10.EN = r_en; bus10.CAI = r_cai; bus10.UP = r_up; bus10.OVF_CLR = r_clr;
         cds = r_cd; buss.SD = r_sd; buss.LOAD = r_ld; buss.D = 4'(r_d);
         buss.EN = r_en; buss.CAI = r_cai; buss.UP = r_up; buss.OVF_CLR = r_clr;
         model_step(10, 1'b0, r_cd, r_sd, r_ld, r_d, r_en, r_cai, r_up, r_clr,
                    mq10, movf10, mcao10);
         model_step(10, 1'b1, r_cd, r_sd, r_ld, r_d, r_en, r_cai, r_up, r_clr,
                    mqs, movfs, mcaos);
         #1;
         check($sformatf("rnd%0d_cao_w", i), bus10.CAO, mcao10);
         check($sformatf("rnd%0d_cao_s", i), buss.CAO, mcaos);
         tick();
         check($sformatf("rnd%0d_q_w", i), bus10.Q, mq10);
         check($sformatf("rnd%0d_ovf_w", i), bus10.OVF, movf10);
         check($sformatf("rnd%0d_q_s", i), buss.Q, mqs);
         check($sformatf("rnd%0d_ovf_s", i), buss.OVF, movfs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
